// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide sequencer that owns the HI/LO registers.
// It performs a shift-add multiply or a restoring divide on operand magnitudes
// over WIDTH cycles. A FIX cycle then applies sign correction and writes HI/LO.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] first,
    input  logic [WIDTH-1:0] second,
    input  logic             abort,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned   CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic               is_div_q;
    logic               sa_q;
    logic               sb_q;
    logic               bzero_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [WIDTH-1:0]   acc_hi_q;
    logic [WIDTH-1:0]   acc_lo_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               busy_q;
    logic               done_q;
    logic               dbz_q;

    // Operand capture values
    logic               sgn_op;
    logic               sa_d;
    logic               sb_d;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    // Per-iteration datapath values
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_hi_d;
    logic [WIDTH-1:0]   mul_lo_d;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [WIDTH-1:0]   div_hi_d;
    logic [WIDTH-1:0]   div_lo_d;

    // Sign-corrected result values
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   res_hi_d;
    logic [WIDTH-1:0]   res_lo_d;

    // Split the incoming operands into sign and magnitude; unsigned ops never carry a sign
    always_comb begin
        sgn_op = ~op[0];
        sa_d   = sgn_op & first[WIDTH-1];
        sb_d   = sgn_op & second[WIDTH-1];
        mag_a  = sa_d ? -first : first;
        mag_b  = sb_d ? -second : second;
    end

    // One shift-add multiply step and one restoring divide step on the shared accumulator
    always_comb begin
        // multiply: multiplier sits in acc_lo and shifts out LSB-first; the product fills acc_hi:acc_lo
        mul_sum   = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? opnd_q : '0)};
        mul_hi_d  = mul_sum[WIDTH:1];
        mul_lo_d  = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        // divide: dividend shifts MSB-first out of acc_lo; quotient bits shift into acc_lo;
        // the partial remainder is kept in acc_hi. The remainder stays below the divisor, so the
        // subtraction fits in WIDTH bits. With a zero divisor, every step subtracts zero, which
        // yields an all-ones quotient with the dividend left as the remainder.
        div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opnd_q};
        div_rem   = div_shift[WIDTH-1:0] - opnd_q;
        div_hi_d  = div_ge ? div_rem : div_shift[WIDTH-1:0];
        div_lo_d  = {acc_lo_q[WIDTH-2:0], div_ge};
    end

    // Sign correction applied in FIX: remainder follows the dividend, product/quotient follow sign XOR
    always_comb begin
        prod     = {acc_hi_q, acc_lo_q};
        prod_fix = (sa_q ^ sb_q) ? -prod : prod;
        quo_fix  = (sa_q ^ sb_q) ? -acc_lo_q : acc_lo_q;
        rem_fix  = sa_q ? -acc_hi_q : acc_hi_q;
        if (is_div_q) begin
            res_hi_d = rem_fix;
            res_lo_d = bzero_q ? '1 : quo_fix;
        end else begin
            res_hi_d = prod_fix[2*WIDTH-1:WIDTH];
            res_lo_d = prod_fix[WIDTH-1:0];
        end
    end

    // Sequencer FSM together with HI/LO ownership and the registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            bzero_q  <= 1'b0;
            opnd_q   <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            if (!busy_q) begin
                if (hi_we) hi_q <= wdata;
                if (lo_we) lo_q <= wdata;
            end
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q  <= S_CALC;
                        busy_q   <= 1'b1;
                        cnt_q    <= '0;
                        is_div_q <= op[1];
                        sa_q     <= sa_d;
                        sb_q     <= sb_d;
                        bzero_q  <= (second == '0);
                        opnd_q   <= op[1] ? mag_b : mag_a;
                        acc_lo_q <= op[1] ? mag_a : mag_b;
                        acc_hi_q <= '0;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_CALC: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        acc_hi_q <= is_div_q ? div_hi_d : mul_hi_d;
                        acc_lo_q <= is_div_q ? div_lo_d : mul_lo_d;
                        if (cnt_q == LAST) begin
                            cnt_q   <= '0;
                            state_q <= S_FIX;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                S_FIX: begin
                    busy_q <= 1'b0;
                    if (abort) begin
                        state_q <= S_IDLE;
                    end else begin
                        hi_q    <= res_hi_d;
                        lo_q    <= res_lo_d;
                        done_q  <= 1'b1;
                        dbz_q   <= is_div_q & bzero_q;
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, hand-written
// multi-cycle sequences, and random operations checked against an arithmetic model.
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'd0;
    logic [W-1:0] first = '0;
    logic [W-1:0] second = '0;
    logic         abort = 1'b0;
    logic         hi_we = 1'b0;
    logic         lo_we = 1'b0;
    logic [W-1:0] wdata = '0;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .first(first), .second(second), .abort(abort),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] eh;
        logic [W-1:0] el;
        logic         ed;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Arithmetic reference: 64-bit products and native truncating division
    task automatic model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] eh, output logic [W-1:0] el, output logic ed);
        longint      sa, sb, p;
        logic [63:0] up;
        ed = 1'b0;
        eh = '0;
        el = '0;
        case (o)
            2'd0: begin
                p = longint'($signed(a)) * longint'($signed(b));
                {eh, el} = p;
            end
            2'd1: begin
                up = {32'b0, a} * {32'b0, b};
                {eh, el} = up;
            end
            default: begin
                if (b == 0) begin
                    el = '1;
                    eh = a;
                    ed = 1'b1;
                end else if (o == 2'd2) begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                    el = 32'(sa / sb);
                    eh = 32'(sa % sb);
                end else begin
                    up = {32'b0, a} / {32'b0, b};
                    el = up[31:0];
                    up = {32'b0, a} % {32'b0, b};
                    eh = up[31:0];
                end
            end
        endcase
    endtask

    // Present a start request for one cycle; returns #1 after the sampling edge (cycle 1)
    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        start  = 1'b1;
        op     = o;
        first  = a;
        second = b;
        tick();
        start = 1'b0;
    endtask

    // Bounded wait for done; tracks busy and div_by_zero qualification along the way
    task automatic wait_done(input int k0, output int k, output bit busy_ok, output bit dbz_ok);
        k = k0;
        busy_ok = 1'b1;
        dbz_ok = 1'b1;
        while (!done && k < 100) begin
            if (!busy) busy_ok = 1'b0;
            if (div_by_zero) dbz_ok = 1'b0;
            tick();
            k++;
        end
        if (done && busy) busy_ok = 1'b0;
    endtask

    task automatic count_done(input int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (done) c++;
        end
    endtask

    task automatic mt_write(input logic [W-1:0] h, input logic [W-1:0] l);
        hi_we = 1'b1; wdata = h; tick(); hi_we = 1'b0;
        lo_we = 1'b1; wdata = l; tick(); lo_we = 1'b0;
    endtask

    vec_t tbl[12];

    initial begin
        int k, c;
        bit bok, dok;
        logic [W-1:0] eh, el;
        logic ed;

        tbl[0]  = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        tbl[1]  = '{2'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        tbl[2]  = '{2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        tbl[3]  = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        tbl[4]  = '{2'd3, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1};
        tbl[5]  = '{2'd2, 32'hFFFFFFF7, 32'h00000000, 32'hFFFFFFF7, 32'hFFFFFFFF, 1'b1};
        tbl[6]  = '{2'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};
        tbl[7]  = '{2'd3, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        tbl[8]  = '{2'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
        tbl[9]  = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        tbl[10] = '{2'd0, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000, 1'b0};
        tbl[11] = '{2'd3, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0};

        // Reset state
        #12;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_dbz", 64'(div_by_zero), 64'd0);
        chk("reset_hi", 64'(hi), 64'd0);
        chk("reset_lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // MTHI/MTLO while idle
        mt_write(32'h11112222, 32'h33334444);
        chk("mt_hi", 64'(hi), 64'h11112222);
        chk("mt_lo", 64'(lo), 64'h33334444);

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            issue(tbl[i].op, tbl[i].a, tbl[i].b);
            wait_done(1, k, bok, dok);
            chk($sformatf("vec%0d_latency", i), 64'(k), 64'd34);
            chk($sformatf("vec%0d_busy", i), 64'(bok), 64'd1);
            chk($sformatf("vec%0d_dbz_qual", i), 64'(dok), 64'd1);
            chk($sformatf("vec%0d_hi", i), 64'(hi), 64'(tbl[i].eh));
            chk($sformatf("vec%0d_lo", i), 64'(lo), 64'(tbl[i].el));
            chk($sformatf("vec%0d_dbz", i), 64'(div_by_zero), 64'(tbl[i].ed));
            tick();
            chk($sformatf("vec%0d_done_pulse", i), 64'(done), 64'd0);
        end

        // Reset in the middle of CALC
        mt_write(32'h00001234, 32'h00005678);
        issue(2'd1, 32'd3, 32'd4);
        repeat (9) tick();
        rst_n = 1'b0;
        #2;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_hi", 64'(hi), 64'd0);
        chk("midrst_lo", 64'(lo), 64'd0);
        tick();
        rst_n = 1'b1;
        count_done(50, c);
        chk("midrst_no_done", 64'(c), 64'd0);

        // Back-to-back: start accepted in the DONE cycle
        issue(2'd1, 32'hFFFFFFFF, 32'd2);
        wait_done(1, k, bok, dok);
        chk("b2b_first_lo", 64'(lo), 64'hFFFFFFFE);
        issue(2'd3, 32'd1000, 32'd10);
        chk("b2b_accept_busy", 64'(busy), 64'd1);
        wait_done(1, k, bok, dok);
        chk("b2b_latency", 64'(k), 64'd34);
        chk("b2b_lo", 64'(lo), 64'd100);
        chk("b2b_hi", 64'(hi), 64'd0);
        // MTLO in the DONE cycle wins over the just-produced quotient
        lo_we = 1'b1; wdata = 32'h0000CAFE;
        tick();
        lo_we = 1'b0;
        chk("done_write_lo", 64'(lo), 64'h0000CAFE);
        chk("done_write_hi", 64'(hi), 64'd0);

        // start while busy is ignored
        issue(2'd1, 32'd6, 32'd7);
        repeat (4) tick();
        issue(2'd2, 32'd100, 32'd3);
        chk("ign_start_busy", 64'(busy), 64'd1);
        wait_done(6, k, bok, dok);
        chk("ign_start_latency", 64'(k), 64'd34);
        chk("ign_start_lo", 64'(lo), 64'd42);
        chk("ign_start_hi", 64'(hi), 64'd0);
        count_done(50, c);
        chk("ign_start_no_second_done", 64'(c), 64'd0);

        // Abort mid-CALC with ignored MT writes while busy
        mt_write(32'hA5A5A5A5, 32'h5A5A5A5A);
        issue(2'd1, 32'd9, 32'd9);
        repeat (9) tick();
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEADBEEF;
        tick();
        hi_we = 1'b0; lo_we = 1'b0;
        chk("busy_write_lo", 64'(lo), 64'h5A5A5A5A);
        repeat (9) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        count_done(50, c);
        chk("abort_no_done", 64'(c), 64'd0);
        chk("abort_hi", 64'(hi), 64'hA5A5A5A5);
        chk("abort_lo", 64'(lo), 64'h5A5A5A5A);

        // Write together with start, and abort in IDLE has no effect
        hi_we = 1'b1; wdata = 32'hABCD0000; abort = 1'b1;
        issue(2'd0, 32'hFFFFFFFD, 32'd7);
        hi_we = 1'b0; abort = 1'b0;
        chk("wstart_hi_now", 64'(hi), 64'hABCD0000);
        chk("idle_abort_busy", 64'(busy), 64'd1);
        wait_done(1, k, bok, dok);
        chk("wstart_latency", 64'(k), 64'd34);
        chk("wstart_hi_result", 64'(hi), 64'hFFFFFFFF);
        chk("wstart_lo_result", 64'(lo), 64'hFFFFFFEB);
        tick();

        // Random operations against the arithmetic model
        for (int i = 0; i < 60; i++) begin
            logic [1:0] ro;
            logic [W-1:0] ra, rb;
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1, 2: rb = 32'($urandom_range(1, 20));
                3: rb = 32'hFFFFFFFF;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) ra = 32'h80000000;
            model(ro, ra, rb, eh, el, ed);
            issue(ro, ra, rb);
            wait_done(1, k, bok, dok);
            chk($sformatf("rnd%0d_op%0d_latency", i, ro), 64'(k), 64'd34);
            chk($sformatf("rnd%0d_op%0d_a%h_b%h_hi", i, ro, ra, rb), 64'(hi), 64'(eh));
            chk($sformatf("rnd%0d_op%0d_a%h_b%h_lo", i, ro, ra, rb), 64'(lo), 64'(el));
            chk($sformatf("rnd%0d_op%0d_dbz", i, ro), 64'(div_by_zero), 64'(ed));
            if ($urandom_range(0, 1) == 0) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide sequencer that owns the architectural HI/LO registers for the MIPS core.
- Accepts MULT/MULTU/DIV/DIVU from the execute stage and runs a shift-add multiply or a restoring divide over WIDTH cycles.
- Holds `busy` high so the pipeline control logic stalls MFHI/MFLO and any new mul/div until `done`.
- The single-cycle ALU stays in the pipeline; this block replaces its combinational mul/div path.

Parameters:
- WIDTH, 32: operand width and number of iteration cycles in CALC.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request pulse; sampled only when busy=0
- op  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- first  in  WIDTH  multiplicand / dividend
- second  in  WIDTH  multiplier / divisor
- abort  in  1  pipeline flush; kills the operation in flight
- hi_we  in  1  MTHI write enable
- lo_we  in  1  MTLO write enable
- wdata  in  WIDTH  MTHI/MTLO data
- busy  out  1  high while an operation is in flight
- done  out  1  one-cycle pulse; hi/lo are valid in the same cycle
- div_by_zero  out  1  qualified by done; set when a DIV/DIVU had second=0
- hi  out  WIDTH  HI register (product upper half / remainder)
- lo  out  WIDTH  LO register (product lower half / quotient)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; hi=lo=0; busy=done=div_by_zero=0; iteration counter=0.
  - A reset mid-operation drops the operation immediately.
- States:
  - IDLE: busy=0. start=1 latches op, the operand magnitudes and the operand signs, then goes to CALC.
  - CALC: busy=1. One iteration per cycle for exactly WIDTH cycles, counter 0..WIDTH-1, then goes to FIX.
  - FIX: busy=1, one cycle.
    - Applies sign correction; signed ops use the magnitudes internally.
    - Writes hi/lo at the edge leaving FIX and registers done=1.
    - Goes to DONE.
  - DONE: busy=0, done=1 for this one cycle.
    - start=1 in DONE is accepted and goes to CALC; otherwise goes to IDLE.
- Latency: start sampled at edge E0 gives done=1 during the cycle after edge E0+WIDTH+1. That is 34 cycles for WIDTH=32.
- start while busy=1 is ignored; no queuing.
- MULT/MULTU: {hi,lo} = full 2*WIDTH-bit product.
  - Signed: the product is negated in FIX when the operand signs differ.
- DIV/DIVU: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
- Signed overflow case, first=0x80000000 and second=0xFFFFFFFF: lo=0x80000000, hi=0, div_by_zero=0.
- second=0 on DIV/DIVU:
  - The full latency is still taken.
  - lo=all ones, hi=first, div_by_zero=1 with done.
- div_by_zero is 0 whenever done=0 or op is a multiply.
- abort=1 in CALC or FIX:
  - Next state is IDLE.
  - hi/lo are unchanged; no done pulse.
  - abort in IDLE or DONE has no effect.
- hi_we/lo_we:
  - Honoured only when busy=0; ignored while busy=1.
  - A write and a start in the same cycle: both take effect. The write lands now, and the result overwrites it at completion.
  - A write in the DONE cycle takes priority over the hi/lo value just produced; the write lands next edge.
- hi/lo hold their value at all other times.

Test Plan:
- Reset mid-CALC: start MULTU, assert rst_n=0 at cycle 10 -> hi=lo=0 and busy=0 asynchronously; no done afterwards.
- MULTU first=0xFFFFFFFF, second=0xFFFFFFFF -> done at cycle 34 with hi=0xFFFFFFFE, lo=0x00000001; busy high for cycles 1..33.
- MULT first=-3, second=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV first=-7, second=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIV first=0x80000000, second=-1 -> lo=0x80000000, hi=0.
- DIVU first=5, second=0 -> lo=0xFFFFFFFF, hi=5, div_by_zero=1 with done.
- Back-to-back and contention:
  - start in the DONE cycle -> second done exactly 34 cycles later.
  - start while busy -> ignored.
  - abort at cycle 20 -> no done, hi/lo unchanged.
  - lo_we while busy -> ignored.
